blockchain_frame_loader: RTL

//  Upstream feeder for the 8-block CBC encipher stage (16-bit blocks, 20-bit key).
//  - Accepts a stream of 16-bit plaintext words over a valid/ready handshake.
//  - Packs them into a 128-bit frame, with word 0 in bits [15:0].
//  - Pads short frames and holds plaintext, init_vec and key stable until the consumer accepts.
//  - Chains the IV across frames from the encipher's last ciphertext block.

---
 rtl/blockchain_frame_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/blockchain_frame_loader.sv
// -----------------------------------------------------------------------------
// blockchain_frame_loader
//
// Purpose:
//   Feeds the 8-block CBC encipher stage. Collects 16-bit plaintext words over
//   a valid/ready handshake and packs them into a 128-bit frame, with word 0 in
//   bits [15:0]. A frame closed early by word_last has its unfilled slots set
//   to PAD_WORD. The frame, its IV and the message key are held stable until
//   the consumer accepts them.
//
// Optional feature (macro CBC_CHAIN_EN):
//   defined   - each follow-on frame of a message takes ct_tail (the last
//               ciphertext block of the previous frame) as its IV, so the whole
//               message forms one continuous CBC chain.
//   undefined - every frame of a message reuses the iv_seed latched at start;
//               ct_tail is unused.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a message (sampled in IDLE only)
//   iv_seed, key_in       IV of the first frame and key, sampled with start
//   word_in/valid/last    plaintext word stream; word_ready = accept
//   ct_tail               ciphertext[127:112] returned from the encipher
//   frame_valid/ready     frame handshake towards the encipher
//   plaintext             packed 128-bit frame
//   init_vec, key         IV for this frame, latched message key
//   frame_words           number of real (non-pad) words in the frame, 1..8
// -----------------------------------------------------------------------------
module blockchain_frame_loader #(
    parameter int          NUM_BLOCKS = 8,
    parameter logic [15:0] PAD_WORD   = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [15:0]  iv_seed,
    input  logic [19:0]  key_in,
    input  logic [15:0]  word_in,
    input  logic         word_valid,
    input  logic         word_last,
    output logic         word_ready,
    input  logic [15:0]  ct_tail,
    output logic         frame_valid,
    input  logic         frame_ready,
    output logic [127:0] plaintext,
    output logic [15:0]  init_vec,
    output logic [19:0]  key,
    output logic [3:0]   frame_words
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_q,       state_d;
    logic [2:0]     cnt_q,         cnt_d;
    logic           last_seen_q,   last_seen_d;
    logic [127:0]   plaintext_q,   plaintext_d;
    logic [15:0]    init_vec_q,    init_vec_d;
    logic [19:0]    key_q,         key_d;
    logic [3:0]     frame_words_q, frame_words_d;

    logic word_fire;
    logic frame_fire;
    logic frame_end;

    // Handshakes only count in the state that raises the matching ready/valid,
    // so stray word_valid/frame_ready elsewhere are ignored.
    assign word_fire  = word_valid && (state_q == FILL);
    assign frame_fire = frame_ready && (state_q == HOLD);
    // word_last only matters when qualified by an accepted word.
    assign frame_end  = word_fire && ((cnt_q == LAST_IDX) || word_last);

`ifndef CBC_CHAIN_EN
    logic unused_ct_tail;
    assign unused_ct_tail = ^ct_tail;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            last_seen_q   <= 1'b0;
            plaintext_q   <= 128'd0;
            init_vec_q    <= 16'd0;
            key_q         <= 20'd0;
            frame_words_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_seen_q   <= last_seen_d;
            plaintext_q   <= plaintext_d;
            init_vec_q    <= init_vec_d;
            key_q         <= key_d;
            frame_words_q <= frame_words_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = FILL;
            FILL:    if (frame_end)  state_d = HOLD;
            HOLD:    if (frame_fire) state_d = last_seen_q ? IDLE : FILL;
            default:                 state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d         = cnt_q;
        last_seen_d   = last_seen_q;
        plaintext_d   = plaintext_q;
        init_vec_d    = init_vec_q;
        key_d         = key_q;
        frame_words_d = frame_words_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d       = key_in;
                    init_vec_d  = iv_seed;
                    plaintext_d = {NUM_BLOCKS{PAD_WORD}};
                    cnt_d       = 3'd0;
                    last_seen_d = 1'b0;
                end
            end
            FILL: begin
                if (word_fire) begin
                    plaintext_d[16*cnt_q +: 16] = word_in;
                    // Wraps to 0 only on the closing word; the next frame
                    // restarts from 0 anyway.
                    cnt_d = cnt_q + 3'd1;
                    if (frame_end) begin
                        frame_words_d = {1'b0, cnt_q} + 4'd1;
                        last_seen_d   = word_last;
                    end
                end
            end
            HOLD: begin
                if (frame_fire && !last_seen_q) begin
                    plaintext_d = {NUM_BLOCKS{PAD_WORD}};
                    cnt_d       = 3'd0;
`ifdef CBC_CHAIN_EN
                    init_vec_d  = ct_tail;
`endif
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        word_ready  = (state_q == FILL);
        frame_valid = (state_q == HOLD);
        plaintext   = plaintext_q;
        init_vec    = init_vec_q;
        key         = key_q;
        frame_words = frame_words_q;
    end

endmodule
